img_sram_arbiter: RTL and testbench

- Shares the single image SRAM port (img_sram_ctrl_t) between NREQ requesters: io RX writer, io TX reader and the convolution engine.
- Round-robin arbitration with burst lock: a requester keeps the port while it holds req, up to MAX_BURST cycles.
- Read data returns to the requester that issued the read, via a tagged latency pipeline.
- Sits between the requester controllers and the img_sram macro wrapper.

---
 rtl/img_sram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_img_sram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : img_sram_arbiter (with img_sram_pkg)
// Purpose  : Shares the single image SRAM port between NREQ requesters
//            (0 = io RX writer, 1 = io TX reader, 2 = convolution engine).
//            Round-robin arbitration with burst lock; read data is returned
//            to the issuing requester through a tagged latency pipeline.
// Ports    : clk, rst         clock, synchronous active-high reset
//            req[NREQ]        level request, held for the whole burst
//            ctrl_in[NREQ]    per-requester SRAM control
//            gnt[NREQ]        registered one-hot-or-zero grant
//            sram_ctrl        muxed control to the SRAM macro
//            sram_dout        SRAM read data, READ_LAT cycles after a read
//            rd_valid[NREQ]   one-hot read-return strobe
//            rd_data          returned read data (0 when no rd_valid)
//            busy             high while a grant is held
//            owner            index of the current or last grantee
// Revision : 1.0 - initial release
// ============================================================================

package img_sram_pkg;
    localparam int IMG_ROW_W = 6;
    localparam int IMG_COL_W = 6;

    typedef struct packed {
        logic                 sense_en;
        logic                 write_en;
        logic [IMG_ROW_W-1:0] row;
        logic [IMG_COL_W-1:0] col;
        logic [7:0]           din;
    } img_sram_ctrl_t;
endpackage

module img_sram_arbiter
    import img_sram_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 256,
    parameter int READ_LAT  = 1,
    localparam int c_OWN_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  img_sram_ctrl_t [NREQ-1:0]  ctrl_in,
    output logic [NREQ-1:0]            gnt,
    output img_sram_ctrl_t             sram_ctrl,
    input  logic [7:0]                 sram_dout,
    output logic [NREQ-1:0]            rd_valid,
    output logic [7:0]                 rd_data,
    output logic                       busy,
    output logic [c_OWN_W-1:0]         owner
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    // burst_cnt saturates at MAX_BURST-1; with MAX_BURST of 0 or 1 it never moves.
    localparam int                 c_CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((MAX_BURST > 1) ? MAX_BURST - 1 : 0);
    localparam logic [c_OWN_W-1:0] c_OWN_RST  = c_OWN_W'(NREQ - 1);
    localparam bit                 c_LIMITED  = (MAX_BURST != 0);

    logic [0:0]         r_state,     w_state_nxt;
    logic [NREQ-1:0]    r_gnt,       w_gnt_nxt;
    logic [c_OWN_W-1:0] r_owner,     w_owner_nxt;
    logic [c_CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;

    logic               w_found;
    logic [c_OWN_W-1:0] w_winner;
    logic [c_OWN_W-1:0] w_cand;
    logic               w_owner_req;
    logic               w_other_req;
    logic               w_at_limit;
    logic               w_rd_access;

    // Read tag pipeline: stage 0 is loaded at the access edge, the last
    // stage lines up with valid sram_dout.
    logic [READ_LAT-1:0] r_tag_vld;
    logic [c_OWN_W-1:0]  r_tag_id [READ_LAT];

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last grantee.
    // ------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        w_cand   = r_owner;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_OWN_W'((32'(r_owner) + 32'(k)) % 32'(NREQ));
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // r_gnt is one-hot of the owner while in GRANT, so masking with it
    // isolates the owner's request from everybody else's.
    assign w_owner_req = |(req & r_gnt);
    assign w_other_req = |(req & ~r_gnt);
    assign w_at_limit  = c_LIMITED && (r_burst_cnt == c_CNT_LAST) && w_other_req;

    // ------------------------------------------------------------------
    // Arbitration FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = c_ST_GRANT;
                    w_gnt_nxt       = NREQ'(1) << w_winner;
                    w_owner_nxt     = w_winner;
                    w_burst_cnt_nxt = '0;
                end
            end
            c_ST_GRANT: begin
                if (w_owner_req && !w_at_limit) begin
                    if (r_burst_cnt != c_CNT_LAST) begin
                        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    end
                end else begin
                    // Always pass through IDLE: guarantees the one-cycle
                    // handover gap, even for a re-grant to the same owner.
                    w_state_nxt = c_ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_gnt       <= '0;
            r_owner     <= c_OWN_RST;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control mux: grantee's control passes straight through, else idle.
    // ------------------------------------------------------------------
    always_comb begin
        sram_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                sram_ctrl = ctrl_in[i];
            end
        end
    end

    // A read only counts while the owner still holds req.
    assign w_rd_access = (r_state == c_ST_GRANT) && w_owner_req &&
                         sram_ctrl.sense_en && !sram_ctrl.write_en;

    // ------------------------------------------------------------------
    // Read tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_rd_access;
            r_tag_id[0]  <= r_owner;
            for (int i = 1; i < READ_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign rd_valid = r_tag_vld[READ_LAT-1] ? (NREQ'(1) << r_tag_id[READ_LAT-1]) : '0;
    assign rd_data  = r_tag_vld[READ_LAT-1] ? sram_dout : 8'h00;

    assign gnt   = r_gnt;
    assign busy  = (r_state == c_ST_GRANT);
    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_img_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_sram_arbiter
// Purpose  : Self-checking bench for img_sram_arbiter. A main instance
//            (MAX_BURST=4, READ_LAT=2) is tracked cycle by cycle against a
//            behavioural model; an unlimited-burst instance shares the inputs
//            and is checked in the preemption vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_sram_arbiter;
    import img_sram_pkg::*;

    localparam int c_NREQ = 3;
    localparam int c_MB   = 4;
    localparam int c_RL   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst;
    logic [c_NREQ-1:0]           req;
    img_sram_ctrl_t [c_NREQ-1:0] ctrl_in;
    logic [c_NREQ-1:0]           gnt, rd_valid;
    img_sram_ctrl_t              sram_ctrl;
    logic [7:0]                  sram_dout, rd_data;
    logic                        busy;
    logic [1:0]                  owner;

    logic [c_NREQ-1:0]           u_gnt, u_rd_valid;
    img_sram_ctrl_t              u_sram_ctrl;
    logic [7:0]                  u_sram_dout, u_rd_data;
    logic                        u_busy;
    logic [1:0]                  u_owner;

    img_sram_arbiter #(.NREQ(c_NREQ), .MAX_BURST(c_MB), .READ_LAT(c_RL)) dut (
        .clk(clk), .rst(rst), .req(req), .ctrl_in(ctrl_in), .gnt(gnt),
        .sram_ctrl(sram_ctrl), .sram_dout(sram_dout), .rd_valid(rd_valid),
        .rd_data(rd_data), .busy(busy), .owner(owner)
    );

    img_sram_arbiter #(.NREQ(c_NREQ), .MAX_BURST(0), .READ_LAT(1)) dut_unl (
        .clk(clk), .rst(rst), .req(req), .ctrl_in(ctrl_in), .gnt(u_gnt),
        .sram_ctrl(u_sram_ctrl), .sram_dout(u_sram_dout), .rd_valid(u_rd_valid),
        .rd_data(u_rd_data), .busy(u_busy), .owner(u_owner)
    );

    // ---------------- reference model state ----------------
    typedef struct { int id; logic [7:0] data; } tag_t;
    int         m_gnt;      // current grantee, -1 when nobody holds the port
    int         m_owner;
    int         m_run;      // cycles the current grantee has held the port
    tag_t       m_pipe[$];  // front = newest, back = what returns this cycle
    logic [7:0] mem [int];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] read_mem(int a);
        if (mem.exists(a)) return mem[a];
        return 8'(a * 37 + 5);
    endfunction

    function automatic int addr_of(img_sram_ctrl_t c);
        return (int'(c.row) << IMG_COL_W) | int'(c.col);
    endfunction

    function automatic img_sram_ctrl_t mk(logic se, logic we, int row, int col, logic [7:0] din);
        img_sram_ctrl_t c;
        c.sense_en = se;
        c.write_en = we;
        c.row      = IMG_ROW_W'(row);
        c.col      = IMG_COL_W'(col);
        c.din      = din;
        return c;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specification's rules, applied to the inputs
    // present at that edge.
    task automatic model_step();
        tag_t t;
        bit   found;
        int   others;
        if (rst) begin
            m_gnt   = -1;
            m_owner = c_NREQ - 1;
            m_run   = 0;
            m_pipe.delete();
            for (int i = 0; i < c_RL; i++) m_pipe.push_back('{-1, 8'h00});
            return;
        end
        t.id   = -1;
        t.data = 8'h00;
        if (m_gnt >= 0 && req[m_gnt] && ctrl_in[m_gnt].sense_en && !ctrl_in[m_gnt].write_en) begin
            t.id   = m_gnt;
            t.data = read_mem(addr_of(ctrl_in[m_gnt]));
        end
        m_pipe.push_front(t);
        void'(m_pipe.pop_back());
        if (m_gnt < 0) begin
            found = 0;
            for (int k = 1; k <= c_NREQ; k++) begin
                int c;
                c = (m_owner + k) % c_NREQ;
                if (!found && req[c]) begin
                    found   = 1;
                    m_gnt   = c;
                    m_owner = c;
                    m_run   = 1;
                end
            end
        end else begin
            others = int'(req) & ~(1 << m_gnt);
            if (req[m_gnt] && !(m_run >= c_MB && others != 0)) m_run++;
            else m_gnt = -1;
        end
    endtask

    // Combinational outputs checked at the falling edge, registered ones
    // just after the rising edge; the SRAM data for this cycle is then driven.
    task automatic tick();
        tag_t           tl;
        img_sram_ctrl_t ec;
        @(negedge clk);
        ec = (m_gnt >= 0) ? ctrl_in[m_gnt] : '0;
        chk("sram_ctrl", sram_ctrl, ec);
        tl = m_pipe[$];
        chk("rd_data", rd_data, (tl.id >= 0) ? tl.data : 8'h00);
        @(posedge clk);
        model_step();
        #1;
        chk("gnt", gnt, (m_gnt >= 0) ? (1 << m_gnt) : 0);
        chk("busy", busy, (m_gnt >= 0) ? 1 : 0);
        chk("owner", owner, m_owner);
        tl = m_pipe[$];
        chk("rd_valid", rd_valid, (tl.id >= 0) ? (1 << tl.id) : 0);
        sram_dout = (tl.id >= 0) ? tl.data : 8'($urandom);
    endtask

    task automatic reset_pulse();
        rst     = 1'b1;
        req     = '0;
        ctrl_in = '0;
        tick();
        rst     = 1'b0;
    endtask

    typedef struct {
        logic              rst;
        logic [c_NREQ-1:0] req;
        logic [c_NREQ-1:0] exp_gnt;
        logic [c_NREQ-1:0] exp_ugnt;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[12];
        int         cnt;
        int         order[$];
        int         zeros;
        logic [7:0] rdat[$];
        int         first_ret;
        logic [2:0] gnt_at_last;
        logic [2:0] prev;
        logic [2:0] first_post;

        // Preemption table: MAX_BURST=4 alternates 4 on / 1 gap; unlimited holds 0.
        tbl[0] = '{1'b1, 3'b000, 3'b000, 3'b000};
        for (int i = 1; i <= 4; i++) tbl[i] = '{1'b0, 3'b011, 3'b001, 3'b001};
        tbl[5] = '{1'b0, 3'b011, 3'b000, 3'b001};
        for (int i = 6; i <= 9; i++) tbl[i] = '{1'b0, 3'b011, 3'b010, 3'b001};
        tbl[10] = '{1'b0, 3'b011, 3'b000, 3'b001};
        tbl[11] = '{1'b0, 3'b011, 3'b001, 3'b001};

        rst       = 1'b1;
        req       = '0;
        ctrl_in   = '0;
        sram_dout = 8'h00;
        u_sram_dout = 8'h00;
        m_pipe.delete();
        for (int i = 0; i < c_RL; i++) m_pipe.push_back('{-1, 8'h00});
        @(posedge clk);
        model_step();
        #1;

        // ---- reset state ----
        tick();
        chk("reset_gnt", gnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_owner", owner, 2);
        chk("reset_rd_valid", rd_valid, 0);
        rst = 1'b0;

        // ---- single requester write burst ----
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            req[0]     = (c < 10);
            ctrl_in[0] = (c < 10) ? mk(1'b1, 1'b1, c, c + 1, 8'($urandom)) : '0;
            tick();
            if (gnt[0]) cnt++;
            if (c == 0) chk("grant_latency", gnt, 3'b001);
        end
        chk("single_burst_len", cnt, 10);

        // ---- round-robin with release after two grant cycles ----
        reset_pulse();
        zeros = 0;
        prev  = '0;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            req = '1;
            for (int i = 0; i < c_NREQ; i++) ctrl_in[i] = mk(1'b0, 1'b1, i, c, 8'(c));
            if (m_gnt >= 0 && m_run == 2) req[m_gnt] = 1'b0;
            tick();
            if (gnt != 0 && prev == 0) begin
                for (int i = 0; i < c_NREQ; i++) if (gnt[i]) order.push_back(i);
                if (order.size() > 1) chk("rr_gap", zeros, 1);
                zeros = 0;
            end
            if (gnt == 0) zeros++;
            prev = gnt;
        end
        chk("rr_count", order.size(), 6);
        for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % 3);

        // ---- preemption vector table ----
        ctrl_in = '0;
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            tick();
            chk("tbl_gnt", gnt, tbl[i].exp_gnt);
            chk("tbl_unlimited_gnt", u_gnt, tbl[i].exp_ugnt);
        end
        rst = 1'b0;

        // ---- read return, latency 2 ----
        reset_pulse();
        mem[(3 << IMG_COL_W) | 4] = 8'h11;
        mem[(3 << IMG_COL_W) | 5] = 8'h22;
        mem[(3 << IMG_COL_W) | 6] = 8'h33;
        first_ret   = -1;
        gnt_at_last = 3'b111;
        for (int c = 0; c < 10; c++) begin
            if (c <= 3) begin
                req        = 3'b010;
                ctrl_in[1] = mk(1'b1, 1'b0, 3, (c <= 1) ? 4 : 3 + c, 8'h00);
            end else begin
                req     = '0;
                ctrl_in = '0;
            end
            tick();
            #1;
            if (rd_valid != 0) begin
                chk("rd_lane", rd_valid, 3'b010);
                if (first_ret < 0) first_ret = c;
                rdat.push_back(rd_data);
                gnt_at_last = gnt;
            end
        end
        chk("rd_count", rdat.size(), 3);
        chk("rd_first_cycle", first_ret, 2);
        for (int k = 0; k < rdat.size() && k < 3; k++) chk("rd_value", rdat[k], 8'h11 * (k + 1));
        chk("rd_last_after_drop", gnt_at_last, 3'b000);

        // ---- reset with a grant held and a read in flight ----
        reset_pulse();
        req        = 3'b100;
        ctrl_in[2] = mk(1'b1, 1'b0, 1, 1, 8'h00);
        tick();
        tick();
        chk("pre_rst_gnt", gnt, 3'b100);
        rst = 1'b1;
        req = 3'b111;
        tick();
        chk("rst_mid_gnt", gnt, 3'b000);
        chk("rst_mid_ctrl", sram_ctrl, 0);
        rst        = 1'b0;
        first_post = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_rd_valid", rd_valid, 0);
            if (first_post == 0) first_post = gnt;
        end
        chk("post_rst_first_grant", first_post, 3'b001);

        // ---- randomized traffic against the model ----
        reset_pulse();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < c_NREQ; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                ctrl_in[i] = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                                int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                                8'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
